pool_regfile_reader: RTL and testbench

//  Read-side sequencer for regfilePooling. Walks the register file through its

---
 rtl/pool_pkg.sv | 16 +
 rtl/pool_max_unit.sv | 14 +
 rtl/pool_regfile_reader.sv | 152 +++++++++++++++
 tb/tb_pool_regfile_reader.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared types and default sizes for the regfilePooling read-side logic.
// Default sizes match the register file instance in regfilePooling.
package pool_pkg;

  localparam int DATA_W  = 16;
  localparam int REG_NUM = 16;
  localparam int ADDR_W  = 4;
  localparam int NWIN_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    OUT
  } pool_rd_state_t;

endpackage

// File: rtl/pool_max_unit.sv
// Combinational signed maximum with a first-load select.
// On ties the accumulator (earlier entry) is kept.
module pool_max_unit #(
  parameter int W = 16
) (
  input  logic         first_i,
  input  logic [W-1:0] acc_i,
  input  logic [W-1:0] sample_i,
  output logic [W-1:0] max_o
);

  assign max_o = (first_i || ($signed(sample_i) > $signed(acc_i))) ? sample_i : acc_i;

endmodule

// File: rtl/pool_regfile_reader.sv
// Read-side sequencer: walks the regfile read port and emits one signed
// max per window of win_size entries on a valid/ready stream.
//
// state | meaning
// IDLE  | waiting for a start command
// READ  | capturing one regfile entry per edge into the accumulator
// OUT   | holding a window result until the downstream accepts it
module pool_regfile_reader #(
  parameter int DATA_W  = pool_pkg::DATA_W,
  parameter int REG_NUM = pool_pkg::REG_NUM,
  parameter int ADDR_W  = pool_pkg::ADDR_W,
  parameter int NWIN_W  = pool_pkg::NWIN_W
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_adrs,
  input  logic [ADDR_W:0]   win_size,
  input  logic [NWIN_W-1:0] num_win,
  output logic [ADDR_W-1:0] rd_adrs,
  input  logic [DATA_W-1:0] rd_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  import pool_pkg::*;

  pool_rd_state_t    state_q, state_d;
  logic [ADDR_W-1:0] rd_adrs_q, rd_adrs_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   win_q, win_d;
  logic [NWIN_W-1:0] nwin_q, nwin_d;
  logic              m_valid_q, m_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              cmd_legal;
  logic              first_cap;
  logic [DATA_W-1:0] max_val;

  assign cmd_legal = (win_size != '0) && (win_size <= (ADDR_W+1)'(REG_NUM)) && (num_win != '0);
  // cnt_q counts remaining captures down from win_q; full count means nothing captured yet
  assign first_cap = (cnt_q == win_q);

  pool_max_unit #(.W(DATA_W)) u_max (
    .first_i  (first_cap),
    .acc_i    (acc_q),
    .sample_i (rd_data),
    .max_o    (max_val)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      rd_adrs_q <= '0;
      acc_q     <= '0;
      m_data_q  <= '0;
      cnt_q     <= '0;
      win_q     <= '0;
      nwin_q    <= '0;
      m_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_adrs_q <= rd_adrs_d;
      acc_q     <= acc_d;
      m_data_q  <= m_data_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      nwin_q    <= nwin_d;
      m_valid_q <= m_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_adrs_d = rd_adrs_q;
    acc_d     = acc_q;
    m_data_d  = m_data_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    nwin_d    = nwin_q;
    m_valid_d = m_valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cmd_legal) begin
            rd_adrs_d = base_adrs;
            busy_d    = 1'b1;
            win_d     = win_size;
            nwin_d    = num_win;
            cnt_d     = win_size;
            state_d   = READ;
          end else begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        acc_d     = max_val;
        rd_adrs_d = rd_adrs_q + ADDR_W'(1);
        cnt_d     = cnt_q - (ADDR_W+1)'(1);
        if (cnt_q == (ADDR_W+1)'(1)) begin
          m_data_d  = max_val;
          m_valid_d = 1'b1;
          state_d   = OUT;
        end
      end
      OUT: begin
        // rd_adrs already points at the next window base, so rd_data is primed
        if (m_ready) begin
          m_valid_d = 1'b0;
          if (nwin_q > NWIN_W'(1)) begin
            nwin_d  = nwin_q - NWIN_W'(1);
            cnt_d   = win_q;
            state_d = READ;
          end else begin
            nwin_d  = '0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_adrs = rd_adrs_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_pool_regfile_reader.sv
// Self-checking bench for pool_regfile_reader: directed scenarios plus
// randomized commands checked against a window-max reference model.
module tb_pool_regfile_reader;
  import pool_pkg::*;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              start = 1'b0;
  logic              m_ready = 1'b0;
  logic [ADDR_W-1:0] base_adrs = '0;
  logic [ADDR_W:0]   win_size = '0;
  logic [NWIN_W-1:0] num_win = '0;
  logic [DATA_W-1:0] rd_data = '0;
  logic [ADDR_W-1:0] rd_adrs;
  logic [DATA_W-1:0] m_data;
  logic              m_valid, busy, done, err;

  logic [DATA_W-1:0] mem [REG_NUM];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Register file read port: samples the address on the falling edge
  always @(negedge clk) rd_data <= mem[rd_adrs];

  pool_regfile_reader #(
    .DATA_W(DATA_W), .REG_NUM(REG_NUM), .ADDR_W(ADDR_W), .NWIN_W(NWIN_W)
  ) dut (
    .clk(clk), .nrst(nrst), .start(start), .base_adrs(base_adrs),
    .win_size(win_size), .num_win(num_win), .rd_adrs(rd_adrs),
    .rd_data(rd_data), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready), .busy(busy), .done(done), .err(err)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int b, input int w, input int n);
    start = 1'b1;
    base_adrs = ADDR_W'(b);
    win_size = (ADDR_W+1)'(w);
    num_win = NWIN_W'(n);
    tick;
    start = 1'b0;
  endtask

  // Signed maximum over window idx of a command, straight from the memory image
  function automatic logic [DATA_W-1:0] ref_max(int b, int w, int idx);
    logic signed [DATA_W-1:0] best, v;
    best = mem[(b + idx * w) % REG_NUM];
    for (int i = 1; i < w; i++) begin
      v = mem[(b + idx * w + i) % REG_NUM];
      if (v > best) best = v;
    end
    return best;
  endfunction

  task automatic test_reset;
    nrst = 1'b0;
    #3;
    checks++;
    if ({m_valid, busy, done, err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {m_valid, busy, done, err});
    end
    checks++;
    if (rd_adrs !== '0 || m_data !== '0) begin
      errors++; $display("FAIL reset_data: rd_adrs=%0d m_data=%h expected 0/0000", rd_adrs, m_data);
    end
    @(posedge clk);
    #1 nrst = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    int k;
    mem[0] = 16'd5; mem[1] = 16'hFFFE; mem[2] = 16'd9; mem[3] = 16'd7;
    m_ready = 1'b1;
    issue(0, 4, 1);
    k = 0;
    do begin tick; k++; end while (!m_valid && k < 40);
    checks++;
    if (!m_valid || k != 4) begin
      errors++; $display("FAIL basic_latency: got %0d edges expected 4", k);
    end
    checks++;
    if (m_data !== 16'd9) begin
      errors++; $display("FAIL basic_data: got %h expected 0009", m_data);
    end
    tick;
    checks++;
    if ({done, busy, m_valid} !== 3'b100) begin
      errors++; $display("FAIL basic_done: done/busy/m_valid got %b expected 100", {done, busy, m_valid});
    end
    tick;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse: done got %b expected 0", done);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_signed;
    mem[4] = 16'h8000; mem[5] = 16'hFFFF;
    issue(4, 2, 1);
    tick; tick;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 16'hFFFF) begin
      errors++; $display("FAIL signed_max: valid=%b data=%h expected 1/ffff", m_valid, m_data);
    end
    m_ready = 1'b1; tick; m_ready = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL signed_done: done got %b expected 1", done);
    end
    tick;
  endtask

  task automatic test_wrap;
    int exp_a [4] = '{14, 15, 0, 1};
    mem[14] = 16'd1; mem[15] = 16'd2; mem[0] = 16'd30; mem[1] = 16'd3;
    issue(14, 4, 1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (int'(rd_adrs) != exp_a[i]) begin
        errors++; $display("FAIL wrap_adrs[%0d]: got %0d expected %0d", i, rd_adrs, exp_a[i]);
      end
      tick;
    end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 16'd30 || rd_adrs !== 4'd2) begin
      errors++; $display("FAIL wrap_result: valid=%b data=%0d adrs=%0d expected 1/30/2", m_valid, m_data, rd_adrs);
    end
    m_ready = 1'b1; tick; m_ready = 1'b0;
    tick;
  endtask

  task automatic test_backpressure;
    mem[6] = 16'hFFFB; mem[7] = 16'd4; mem[8] = 16'd100; mem[9] = 16'hFF9C;
    mem[3] = 16'h0042;
    issue(6, 2, 2);
    tick; tick;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 16'd4) begin
      errors++; $display("FAIL bp_first: valid=%b data=%h expected 1/0004", m_valid, m_data);
    end
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if (m_valid !== 1'b1 || m_data !== 16'd4 || rd_adrs !== 4'd8 || done !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d]: valid=%b data=%h adrs=%0d done=%b expected 1/0004/8/0",
                           i, m_valid, m_data, rd_adrs, done);
      end
    end
    m_ready = 1'b1; tick; m_ready = 1'b0;
    checks++;
    if ({m_valid, busy, done} !== 3'b010) begin
      errors++; $display("FAIL bp_accept1: valid/busy/done got %b expected 010", {m_valid, busy, done});
    end
    tick;
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL bp_early: m_valid got %b expected 0", m_valid);
    end
    tick;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 16'd100 || rd_adrs !== 4'd10) begin
      errors++; $display("FAIL bp_second: valid=%b data=%h adrs=%0d expected 1/0064/10", m_valid, m_data, rd_adrs);
    end
    m_ready = 1'b1; tick; m_ready = 1'b0;
    checks++;
    if ({done, busy} !== 2'b10) begin
      errors++; $display("FAIL bp_done: done/busy got %b expected 10", {done, busy});
    end
    // start in the cycle that shows done, with a single-entry window
    issue(3, 1, 1);
    checks++;
    if ({busy, rd_adrs} !== {1'b1, 4'd3}) begin
      errors++; $display("FAIL restart_accept: busy=%b adrs=%0d expected 1/3", busy, rd_adrs);
    end
    tick;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 16'h0042 || rd_adrs !== 4'd4) begin
      errors++; $display("FAIL win1_result: valid=%b data=%h adrs=%0d expected 1/0042/4", m_valid, m_data, rd_adrs);
    end
    m_ready = 1'b1; tick; m_ready = 1'b0;
    tick;
  endtask

  task automatic test_illegal;
    int ws [3] = '{0, 17, 4};
    int ns [3] = '{1, 1, 0};
    logic [ADDR_W-1:0] prev;
    for (int i = 0; i < 3; i++) begin
      prev = rd_adrs;
      issue(9, ws[i], ns[i]);
      checks++;
      if ({err, done, busy, m_valid} !== 4'b1100 || rd_adrs !== prev) begin
        errors++; $display("FAIL illegal[%0d]: err/done/busy/valid=%b adrs=%0d expected 1100/%0d",
                           i, {err, done, busy, m_valid}, rd_adrs, prev);
      end
      tick;
      checks++;
      if ({err, done, m_valid} !== 3'b000) begin
        errors++; $display("FAIL illegal_pulse[%0d]: err/done/valid=%b expected 000", i, {err, done, m_valid});
      end
    end
  endtask

  task automatic test_ignored_start;
    logic [DATA_W-1:0] exp_d;
    for (int i = 0; i < REG_NUM; i++) mem[i] = DATA_W'($urandom);
    exp_d = ref_max(2, 4, 0);
    issue(2, 4, 1);
    tick;
    start = 1'b1; base_adrs = 4'd12; win_size = 5'd1; num_win = 8'd5;
    tick;
    start = 1'b0;
    checks++;
    if (rd_adrs !== 4'd4 || m_valid !== 1'b0) begin
      errors++; $display("FAIL busy_start_adrs: adrs=%0d valid=%b expected 4/0", rd_adrs, m_valid);
    end
    tick; tick;
    checks++;
    if (m_valid !== 1'b1 || m_data !== exp_d || rd_adrs !== 4'd6) begin
      errors++; $display("FAIL busy_start_result: valid=%b data=%h adrs=%0d expected 1/%h/6",
                         m_valid, m_data, rd_adrs, exp_d);
    end
    m_ready = 1'b1; tick; m_ready = 1'b0;
    checks++;
    if ({done, busy} !== 2'b10) begin
      errors++; $display("FAIL busy_start_done: done/busy got %b expected 10", {done, busy});
    end
    tick;
  endtask

  task automatic test_reset_midop;
    issue(0, 8, 1);
    tick; tick; tick;
    nrst = 1'b0;
    #1;
    checks++;
    if ({m_valid, busy, done, err} !== 4'b0000 || rd_adrs !== '0 || m_data !== '0) begin
      errors++; $display("FAIL midop_reset: flags=%b adrs=%0d data=%h expected 0000/0/0000",
                         {m_valid, busy, done, err}, rd_adrs, m_data);
    end
    @(posedge clk);
    #1 nrst = 1'b1;
    tick;
    test_basic();
  endtask

  task automatic test_random;
    int b, w, n, k, stall;
    logic [DATA_W-1:0] exp_d, held;
    for (int c = 0; c < 25; c++) begin
      for (int i = 0; i < REG_NUM; i++) mem[i] = DATA_W'($urandom);
      b = $urandom_range(0, REG_NUM - 1);
      w = $urandom_range(1, REG_NUM);
      n = $urandom_range(1, 3);
      m_ready = 1'b0;
      issue(b, w, n);
      for (int win = 0; win < n; win++) begin
        exp_d = ref_max(b, w, win);
        k = 0;
        do begin tick; k++; end while (!m_valid && k < 40);
        checks++;
        if (!m_valid || k != w) begin
          errors++; $display("FAIL rnd_latency c%0d w%0d: got %0d edges expected %0d", c, win, k, w);
        end
        checks++;
        if (m_data !== exp_d || int'(rd_adrs) != (b + (win + 1) * w) % REG_NUM) begin
          errors++; $display("FAIL rnd_result c%0d w%0d: data=%h adrs=%0d expected %h/%0d",
                             c, win, m_data, rd_adrs, exp_d, (b + (win + 1) * w) % REG_NUM);
        end
        held = m_data;
        stall = $urandom_range(0, 3);
        for (int s = 0; s < stall; s++) begin
          tick;
          checks++;
          if (m_valid !== 1'b1 || m_data !== held) begin
            errors++; $display("FAIL rnd_hold c%0d w%0d: valid=%b data=%h expected 1/%h", c, win, m_valid, m_data, held);
          end
        end
        m_ready = 1'b1; tick; m_ready = 1'b0;
        checks++;
        if (done !== (win == n - 1) || busy !== (win != n - 1)) begin
          errors++; $display("FAIL rnd_done c%0d w%0d: done=%b busy=%b expected %b/%b",
                             c, win, done, busy, win == n - 1, win != n - 1);
        end
      end
      tick;
    end
  endtask

  initial begin
    for (int i = 0; i < REG_NUM; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_signed();
    test_wrap();
    test_backpressure();
    test_illegal();
    test_ignored_start();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
